// File: rtl/data_bus_arbiter.sv
// -----------------------------------------------------------------------------
// data_bus_arbiter
//
// Shares one req/gnt/rvalid data-memory port between two masters:
//   M0 = processor data port, M1 = secondary master (DMA / loader).
// The address phase is a combinational pass-through of the selected master
// (round-robin when both request; a stalled request is locked until granted).
// An in-order ID FIFO records the issuer of each granted transaction so that
// every slave response is routed back to the master that issued it.
//
// Handshake: a master holds mN_req (and its address-phase signals) until it
// sees mN_gnt in the same cycle; mN_rvalid qualifies mN_rdata for one cycle.
// The slave side follows the same rules: s_req is held until s_gnt, responses
// come back in order, at least one cycle after their grant.
//
// Ports
//   clk, res                         clock, synchronous active-high reset
//   m0_* / m1_*                      master ports (req/addr/we/be/wdata in,
//                                    gnt/rvalid/rdata out)
//   s_*                              slave port (req/addr/we/be/wdata out,
//                                    gnt/rvalid/rdata in)
//   dbg_state_o                      FSM state (0 = IDLE, 1 = LOCKED)
//   dbg_count_o                      number of outstanding transactions
// -----------------------------------------------------------------------------
module data_bus_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MAX_OUT = 2
) (
   input  logic                           clk,
   input  logic                           res,
   // master 0
   input  logic                           m0_req,
   output logic                           m0_gnt,
   output logic                           m0_rvalid,
   input  logic [ADDR_W-1:0]              m0_addr,
   input  logic                           m0_we,
   input  logic [DATA_W/8-1:0]            m0_be,
   input  logic [DATA_W-1:0]              m0_wdata,
   output logic [DATA_W-1:0]              m0_rdata,
   // master 1
   input  logic                           m1_req,
   output logic                           m1_gnt,
   output logic                           m1_rvalid,
   input  logic [ADDR_W-1:0]              m1_addr,
   input  logic                           m1_we,
   input  logic [DATA_W/8-1:0]            m1_be,
   input  logic [DATA_W-1:0]              m1_wdata,
   output logic [DATA_W-1:0]              m1_rdata,
   // slave
   output logic                           s_req,
   input  logic                           s_gnt,
   input  logic                           s_rvalid,
   output logic [ADDR_W-1:0]              s_addr,
   output logic                           s_we,
   output logic [DATA_W/8-1:0]            s_be,
   output logic [DATA_W-1:0]              s_wdata,
   input  logic [DATA_W-1:0]              s_rdata,
   // debug
   output logic                           dbg_state_o,
   output logic [$clog2(MAX_OUT+1)-1:0]   dbg_count_o
);

   localparam int CNT_W = $clog2(MAX_OUT + 1);
   localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUT);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUT - 1);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_e;

   state_e               state_q;
   logic                 last_gnt_q;
   logic                 lock_id_q;
   logic                 res_q;          // high in the cycle right after reset
   logic                 fifo_q [MAX_OUT];
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]     count_q,  count_d;

   logic                 blk;
   logic                 full;
   logic                 empty;
   logic                 sel;
   logic                 grant;
   logic                 pop;
   logic                 head;

   // Selection and slave request. Outputs are held quiet during reset and
   // for the cycle after it (blk), even if masters are already requesting.
   always_comb begin
      blk   = res | res_q;
      full  = (count_q == CNT_FULL);
      empty = (count_q == '0);
      sel   = 1'b0;
      s_req = 1'b0;
      if (!blk) begin
         if (state_q == ST_LOCKED) begin
            // A stalled request keeps the bus until granted; full cannot be
            // reached here since no push happened since the lock was taken.
            sel   = lock_id_q;
            s_req = lock_id_q ? m1_req : m0_req;
         end else begin
            sel   = (m0_req & m1_req) ? ~last_gnt_q : m1_req;
            s_req = (m0_req | m1_req) & ~full;
         end
      end
      grant = s_req & s_gnt;
      head  = fifo_q[rd_ptr_q];
      // A response with nothing outstanding is dropped without underflow.
      pop   = s_rvalid & ~empty & ~blk;
   end

   // FIFO pointer / occupancy next-state
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (grant) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      case ({grant, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (res) begin
         state_q    <= ST_IDLE;
         last_gnt_q <= 1'b1;   // M0 wins the first contention
         lock_id_q  <= 1'b0;
         res_q      <= 1'b1;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         for (int i = 0; i < MAX_OUT; i++) fifo_q[i] <= 1'b0;
      end else begin
         res_q    <= 1'b0;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         if (grant) fifo_q[wr_ptr_q] <= sel;
         case (state_q)
            ST_IDLE: begin
               if (grant) begin
                  last_gnt_q <= sel;
               end else if (s_req) begin
                  lock_id_q <= sel;
                  state_q   <= ST_LOCKED;
               end
            end
            ST_LOCKED: begin
               if (grant) begin
                  last_gnt_q <= lock_id_q;
                  state_q    <= ST_IDLE;
               end else if (!s_req) begin
                  // requester withdrew without a grant: release the lock
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign m0_gnt    = grant & ~sel;
   assign m1_gnt    = grant &  sel;
   assign m0_rvalid = pop & ~head;
   assign m1_rvalid = pop &  head;
   assign m0_rdata  = s_rdata;
   assign m1_rdata  = s_rdata;

   assign s_addr    = sel ? m1_addr  : m0_addr;
   assign s_we      = sel ? m1_we    : m0_we;
   assign s_be      = sel ? m1_be    : m0_be;
   assign s_wdata   = sel ? m1_wdata : m0_wdata;

   assign dbg_state_o = state_q;
   assign dbg_count_o = count_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
module tb_data_bus_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk, res;
   logic          m0_req, m0_gnt, m0_rvalid, m0_we;
   logic [AW-1:0] m0_addr;
   logic [3:0]    m0_be;
   logic [DW-1:0] m0_wdata, m0_rdata;
   logic          m1_req, m1_gnt, m1_rvalid, m1_we;
   logic [AW-1:0] m1_addr;
   logic [3:0]    m1_be;
   logic [DW-1:0] m1_wdata, m1_rdata;
   logic          s_req, s_gnt, s_rvalid, s_we;
   logic [AW-1:0] s_addr;
   logic [3:0]    s_be;
   logic [DW-1:0] s_wdata, s_rdata;
   logic          dbg_state;
   logic [1:0]    dbg_count;

   // scoreboard entry = {issuer id, response data the slave will return}
   logic [DW:0]   exp_q[$];
   logic [DW:0]   e;
   logic          exp_last;
   logic          exp_id;
   int            total, bad;

   data_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUT(2)) dut (
      .clk(clk), .res(res),
      .m0_req(m0_req), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_addr(m0_addr),
      .m0_we(m0_we), .m0_be(m0_be), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_addr(m1_addr),
      .m1_we(m1_we), .m1_be(m1_be), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
      .s_req(s_req), .s_gnt(s_gnt), .s_rvalid(s_rvalid), .s_addr(s_addr),
      .s_we(s_we), .s_be(s_be), .s_wdata(s_wdata), .s_rdata(s_rdata),
      .dbg_state_o(dbg_state), .dbg_count_o(dbg_count)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // driver tasks
   task automatic set_idle();
      m0_req = 0; m0_we = 0; m0_be = 4'hF; m0_addr = '0; m0_wdata = '0;
      m1_req = 0; m1_we = 0; m1_be = 4'hF; m1_addr = '0; m1_wdata = '0;
      s_gnt = 0; s_rvalid = 0; s_rdata = '0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      set_idle();
      res = 1; m0_req = 1; m1_req = 1; m0_addr = 32'hA0; m1_addr = 32'hB0;
      s_gnt = 1; s_rvalid = 1;
      @(negedge clk);
      total++; if ({s_req, m0_gnt, m1_gnt} !== 3'b000) begin bad++; $display("FAIL rst_req_gnt: got %b want 000", {s_req, m0_gnt, m1_gnt}); end
      total++; if ({m0_rvalid, m1_rvalid} !== 2'b00) begin bad++; $display("FAIL rst_rvalid: got %b want 00", {m0_rvalid, m1_rvalid}); end
      total++; if (s_addr !== 32'hA0) begin bad++; $display("FAIL rst_addr: got %h want %h", s_addr, 32'hA0); end
      tick(); tick();
      res = 0;
      @(negedge clk);
      total++; if ({s_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 5'b0) begin bad++; $display("FAIL rst_after: got %b want 00000", {s_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}); end
      total++; if ({dbg_state, dbg_count} !== 3'b000) begin bad++; $display("FAIL rst_state_count: got %b want 000", {dbg_state, dbg_count}); end
      tick();
      set_idle();
      exp_q.delete();
      exp_last = 1'b1;
      tick();
   endtask

   // single M0 read, 1-cycle response
   task automatic test_single_read();
      m0_req = 1; m0_addr = 32'h100; s_gnt = 1;
      @(negedge clk);
      total++; if ({m1_gnt, m0_gnt} !== 2'b01) begin bad++; $display("FAIL sr_gnt: got %b want 01", {m1_gnt, m0_gnt}); end
      total++; if (s_addr !== 32'h100 || s_req !== 1'b1) begin bad++; $display("FAIL sr_addr: got %h/%b want 100/1", s_addr, s_req); end
      exp_q.push_back({1'b0, 32'hDEADBEEF}); exp_last = 1'b0;
      tick();
      m0_req = 0; s_gnt = 0;
      e = exp_q.pop_front(); s_rvalid = 1; s_rdata = e[DW-1:0];
      @(negedge clk);
      total++; if ({m1_rvalid, m0_rvalid} !== 2'b01) begin bad++; $display("FAIL sr_rvalid: got %b want 01", {m1_rvalid, m0_rvalid}); end
      total++; if (m0_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL sr_rdata: got %h want deadbeef", m0_rdata); end
      total++; if (m1_gnt !== 1'b0) begin bad++; $display("FAIL sr_m1_gnt: got %b want 0", m1_gnt); end
      tick();
      set_idle(); tick();
   endtask

   // both masters request continuously; M1 issues writes
   task automatic test_round_robin();
      m0_req = 1; m1_req = 1; m1_we = 1; m1_be = 4'h3; s_gnt = 1;
      for (int i = 0; i < 6; i++) begin
         m0_addr = 32'h1000 + i; m1_addr = 32'h2000 + i; m1_wdata = 32'hA000 + i;
         if (i > 0) begin e = exp_q.pop_front(); s_rvalid = 1; s_rdata = e[DW-1:0]; end
         else s_rvalid = 0;
         exp_id = ~exp_last;
         @(negedge clk);
         total++; if ({m1_gnt, m0_gnt} !== (exp_id ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rr_gnt%0d: got %b want id %0d", i, {m1_gnt, m0_gnt}, exp_id); end
         total++; if (s_addr !== (exp_id ? m1_addr : m0_addr) || s_we !== exp_id) begin bad++; $display("FAIL rr_mux%0d: got %h/%b want id %0d", i, s_addr, s_we, exp_id); end
         if (exp_id) begin
            total++; if (s_wdata !== m1_wdata || s_be !== 4'h3) begin bad++; $display("FAIL rr_wdata%0d: got %h/%h want %h/3", i, s_wdata, s_be, m1_wdata); end
         end
         if (i > 0) begin
            total++; if ({m1_rvalid, m0_rvalid} !== (e[DW] ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rr_rvalid%0d: got %b want id %0d", i, {m1_rvalid, m0_rvalid}, e[DW]); end
            total++; if ((e[DW] ? m1_rdata : m0_rdata) !== e[DW-1:0]) begin bad++; $display("FAIL rr_rdata%0d: got %h want %h", i, (e[DW] ? m1_rdata : m0_rdata), e[DW-1:0]); end
         end
         exp_q.push_back({exp_id, 32'($urandom)}); exp_last = exp_id;
         tick();
      end
      m0_req = 0; m1_req = 0; s_gnt = 0;
      e = exp_q.pop_front(); s_rvalid = 1; s_rdata = e[DW-1:0];
      @(negedge clk);
      total++; if ({m1_rvalid, m0_rvalid} !== (e[DW] ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rr_rvalid_last: got %b want id %0d", {m1_rvalid, m0_rvalid}, e[DW]); end
      tick();
      set_idle(); tick();
   endtask

   // stalled M0 request keeps the bus while M1 waits
   task automatic test_locked();
      m0_req = 1; m0_addr = 32'h200;
      for (int c = 0; c < 3; c++) begin
         if (c == 1) begin m1_req = 1; m1_addr = 32'h300; end
         @(negedge clk);
         total++; if (s_addr !== 32'h200 || s_req !== 1'b1 || {m0_gnt, m1_gnt} !== 2'b00) begin bad++; $display("FAIL lk_hold%0d: got %h/%b/%b want 200/1/00", c, s_addr, s_req, {m0_gnt, m1_gnt}); end
         if (c > 0) begin
            total++; if (dbg_state !== 1'b1) begin bad++; $display("FAIL lk_state%0d: got %b want 1", c, dbg_state); end
         end
         tick();
      end
      s_gnt = 1;
      @(negedge clk);
      total++; if ({m1_gnt, m0_gnt} !== 2'b01 || s_addr !== 32'h200) begin bad++; $display("FAIL lk_gnt0: got %b/%h want 01/200", {m1_gnt, m0_gnt}, s_addr); end
      exp_q.push_back({1'b0, 32'($urandom)}); exp_last = 1'b0;
      tick();
      m0_req = 0;
      @(negedge clk);
      total++; if ({m1_gnt, m0_gnt} !== 2'b10 || s_addr !== 32'h300) begin bad++; $display("FAIL lk_gnt1: got %b/%h want 10/300", {m1_gnt, m0_gnt}, s_addr); end
      exp_q.push_back({1'b1, 32'($urandom)}); exp_last = 1'b1;
      tick();
      m1_req = 0; s_gnt = 0;
      for (int c = 0; c < 2; c++) begin
         e = exp_q.pop_front(); s_rvalid = 1; s_rdata = e[DW-1:0];
         @(negedge clk);
         total++; if ({m1_rvalid, m0_rvalid} !== (e[DW] ? 2'b10 : 2'b01)) begin bad++; $display("FAIL lk_rvalid%0d: got %b want id %0d", c, {m1_rvalid, m0_rvalid}, e[DW]); end
         tick();
      end
      set_idle(); tick();
   endtask

   // FIFO full blocks new requests until a response frees a slot
   task automatic test_full();
      m0_req = 1; m1_req = 1; s_gnt = 1;
      for (int c = 0; c < 2; c++) begin
         exp_id = ~exp_last;
         @(negedge clk);
         total++; if ({m1_gnt, m0_gnt} !== (exp_id ? 2'b10 : 2'b01)) begin bad++; $display("FAIL fu_gnt%0d: got %b want id %0d", c, {m1_gnt, m0_gnt}, exp_id); end
         exp_q.push_back({exp_id, 32'($urandom)}); exp_last = exp_id;
         tick();
      end
      @(negedge clk);
      total++; if ({s_req, m0_gnt, m1_gnt} !== 3'b000 || dbg_count !== 2'd2) begin bad++; $display("FAIL fu_block: got %b cnt %0d want 000 cnt 2", {s_req, m0_gnt, m1_gnt}, dbg_count); end
      tick();
      e = exp_q.pop_front(); s_rvalid = 1; s_rdata = e[DW-1:0];
      @(negedge clk);
      total++; if ({m1_rvalid, m0_rvalid} !== (e[DW] ? 2'b10 : 2'b01)) begin bad++; $display("FAIL fu_rvalid: got %b want id %0d", {m1_rvalid, m0_rvalid}, e[DW]); end
      total++; if (s_req !== 1'b0) begin bad++; $display("FAIL fu_still_blocked: got %b want 0", s_req); end
      tick();
      s_rvalid = 0;
      exp_id = ~exp_last;
      @(negedge clk);
      total++; if (s_req !== 1'b1 || {m1_gnt, m0_gnt} !== (exp_id ? 2'b10 : 2'b01)) begin bad++; $display("FAIL fu_reassert: got %b/%b want 1 id %0d", s_req, {m1_gnt, m0_gnt}, exp_id); end
      exp_q.push_back({exp_id, 32'($urandom)}); exp_last = exp_id;
      tick();
      m0_req = 0; m1_req = 0; s_gnt = 0;
      for (int c = 0; c < 2; c++) begin
         e = exp_q.pop_front(); s_rvalid = 1; s_rdata = e[DW-1:0];
         @(negedge clk);
         total++; if ({m1_rvalid, m0_rvalid} !== (e[DW] ? 2'b10 : 2'b01) || (e[DW] ? m1_rdata : m0_rdata) !== e[DW-1:0]) begin bad++; $display("FAIL fu_drain%0d: got %b want id %0d", c, {m1_rvalid, m0_rvalid}, e[DW]); end
         tick();
      end
      set_idle(); tick();
   endtask

   // grant and response in the same cycle with one outstanding
   task automatic test_push_pop();
      m0_req = 1; s_gnt = 1;
      @(negedge clk);
      total++; if ({m1_gnt, m0_gnt} !== 2'b01) begin bad++; $display("FAIL pp_gnt0: got %b want 01", {m1_gnt, m0_gnt}); end
      exp_q.push_back({1'b0, 32'($urandom)}); exp_last = 1'b0;
      tick();
      m0_req = 0; m1_req = 1;
      e = exp_q.pop_front(); s_rvalid = 1; s_rdata = e[DW-1:0];
      @(negedge clk);
      total++; if ({m1_gnt, m0_gnt} !== 2'b10) begin bad++; $display("FAIL pp_gnt1: got %b want 10", {m1_gnt, m0_gnt}); end
      total++; if ({m1_rvalid, m0_rvalid} !== 2'b01 || m0_rdata !== e[DW-1:0]) begin bad++; $display("FAIL pp_pop_old: got %b/%h want 01/%h", {m1_rvalid, m0_rvalid}, m0_rdata, e[DW-1:0]); end
      total++; if (dbg_count !== 2'd1) begin bad++; $display("FAIL pp_cnt_a: got %0d want 1", dbg_count); end
      exp_q.push_back({1'b1, 32'($urandom)}); exp_last = 1'b1;
      tick();
      m1_req = 0; s_gnt = 0;
      e = exp_q.pop_front(); s_rvalid = 1; s_rdata = e[DW-1:0];
      @(negedge clk);
      total++; if (dbg_count !== 2'd1) begin bad++; $display("FAIL pp_cnt_b: got %0d want 1", dbg_count); end
      total++; if ({m1_rvalid, m0_rvalid} !== 2'b10 || m1_rdata !== e[DW-1:0]) begin bad++; $display("FAIL pp_pop_new: got %b/%h want 10/%h", {m1_rvalid, m0_rvalid}, m1_rdata, e[DW-1:0]); end
      tick();
      s_rvalid = 0;
      @(negedge clk);
      total++; if (dbg_count !== 2'd0) begin bad++; $display("FAIL pp_cnt_c: got %0d want 0", dbg_count); end
      tick();
      set_idle(); tick();
   endtask

   // reset while locked with a transaction outstanding
   task automatic test_reset_mid();
      m0_req = 1; m1_req = 1; s_gnt = 1;
      exp_id = ~exp_last;
      @(negedge clk);
      total++; if ({m1_gnt, m0_gnt} !== (exp_id ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rm_gnt: got %b want id %0d", {m1_gnt, m0_gnt}, exp_id); end
      exp_q.push_back({exp_id, 32'($urandom)}); exp_last = exp_id;
      tick();
      s_gnt = 0;
      @(negedge clk);
      total++; if (s_req !== 1'b1 || dbg_count !== 2'd1) begin bad++; $display("FAIL rm_pre: got %b cnt %0d want 1 cnt 1", s_req, dbg_count); end
      tick();
      res = 1; s_rvalid = 1; s_rdata = 32'h5555AAAA;
      @(negedge clk);
      total++; if (dbg_state !== 1'b1) begin bad++; $display("FAIL rm_locked: got %b want 1", dbg_state); end
      total++; if ({s_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 5'b0) begin bad++; $display("FAIL rm_in_res: got %b want 00000", {s_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}); end
      tick();
      res = 0;
      exp_q.delete(); exp_last = 1'b1;
      @(negedge clk);
      total++; if ({s_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 5'b0) begin bad++; $display("FAIL rm_after: got %b want 00000", {s_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}); end
      total++; if ({dbg_state, dbg_count} !== 3'b000) begin bad++; $display("FAIL rm_flushed: got %b want 000", {dbg_state, dbg_count}); end
      tick();
      s_gnt = 1;
      @(negedge clk);
      total++; if ({m1_gnt, m0_gnt} !== 2'b01) begin bad++; $display("FAIL rm_first_m0: got %b want 01", {m1_gnt, m0_gnt}); end
      total++; if ({m1_rvalid, m0_rvalid} !== 2'b00) begin bad++; $display("FAIL rm_stray: got %b want 00", {m1_rvalid, m0_rvalid}); end
      exp_q.push_back({1'b0, 32'($urandom)}); exp_last = 1'b0;
      tick();
      m0_req = 0; m1_req = 0; s_gnt = 0;
      e = exp_q.pop_front(); s_rvalid = 1; s_rdata = e[DW-1:0];
      @(negedge clk);
      total++; if ({m1_rvalid, m0_rvalid} !== 2'b01 || m0_rdata !== e[DW-1:0]) begin bad++; $display("FAIL rm_resp: got %b/%h want 01/%h", {m1_rvalid, m0_rvalid}, m0_rdata, e[DW-1:0]); end
      tick();
      set_idle(); tick();
   endtask

   initial begin
      total = 0; bad = 0;
      res = 1;
      set_idle();
      test_reset();
      test_single_read();
      test_round_robin();
      test_locked();
      test_full();
      test_push_pop();
      test_reset_mid();
      total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d want 0", exp_q.size()); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
